midi_note_parser: RTL

//   Parses the received MIDI byte stream (one byte per i_byte_valid strobe from the UART receiver)

---
 rtl/midi_note_parser_pkg.sv | 38 +++
 rtl/midi_note_parser_if.sv | 21 ++
 rtl/midi_note_parser_status_decode.sv | 32 +++
 rtl/midi_note_parser.sv | 126 ++++++++++++
 4 files changed

// File: rtl/midi_note_parser_pkg.sv
// Shared MIDI constants, FSM state encoding and byte classification for the note parser.
// Imported by the status decoder and the parser top.
package midi_note_parser_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] PBEND    = 4'hE;

   localparam logic [7:0] BYTE_SYS = 8'hF0;
   localparam logic [7:0] BYTE_RT  = 8'hF8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_D1,
      ST_D2,
      ST_SKIP1,
      ST_SKIP2
   } state_e;

   typedef enum logic [1:0] {
      CLS_DATA,
      CLS_STATUS,
      CLS_SYS,
      CLS_RT
   } byte_class_e;

   function automatic byte_class_e classify(input logic [7:0] b);
      if (b >= BYTE_RT)       return CLS_RT;
      else if (b >= BYTE_SYS) return CLS_SYS;
      else if (b[7])          return CLS_STATUS;
      else                    return CLS_DATA;
   endfunction

endpackage

// File: rtl/midi_note_parser_if.sv
// Byte stream in, note events out. The parser takes the slave side, the byte source the master side.
interface midi_note_parser_if;
   logic [7:0] i_byte;
   logic       i_byte_valid;
   logic [6:0] o_note;
   logic [6:0] o_velocity;
   logic       o_gate;
   logic       o_note_on;
   logic       o_note_off;
   logic       o_err;

   modport slave (
      input  i_byte, i_byte_valid,
      output o_note, o_velocity, o_gate, o_note_on, o_note_off, o_err
   );

   modport master (
      output i_byte, i_byte_valid,
      input  o_note, o_velocity, o_gate, o_note_on, o_note_off, o_err
   );
endinterface

// File: rtl/midi_note_parser_status_decode.sv
// Combinational status-byte decoder: tells whether a channel status byte starts a note message
// for this parser, and otherwise how many data bytes to skip.
module midi_status_decode
   import midi_note_parser_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic [7:0] status_i,
   output logic       is_note_o,
   output logic [1:0] skip_len_o
);

   logic chan_match;

   assign chan_match = OMNI || (status_i[3:0] == CHANNEL);

   always_comb begin
      is_note_o  = 1'b0;
      skip_len_o = 2'd2;
      unique case (status_i[7:4])
         NOTE_OFF, NOTE_ON: begin
            is_note_o  = chan_match;
            skip_len_o = 2'd2;
         end
         PROG, CH_AT:         skip_len_o = 2'd1;
         POLY_AT, CC, PBEND:  skip_len_o = 2'd2;
         default:             skip_len_o = 2'd2;
      endcase
   end

endmodule

// File: rtl/midi_note_parser.sv
// Monophonic MIDI note parser: running status, channel filtering and real-time byte transparency,
// producing last-note-priority note/velocity/gate plus single-cycle event pulses.
module midi_note_parser
   import midi_note_parser_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   midi_note_parser_if.slave   bus
);

   state_e      state_q, state_d;
   logic        is_on_q, is_on_d;
   logic [1:0]  skip_len_q, skip_len_d;
   logic [6:0]  key_q, key_d;
   logic [6:0]  note_q, note_d;
   logic [6:0]  vel_q, vel_d;
   logic        gate_q, gate_d;
   logic        on_q, on_d;
   logic        off_q, off_d;
   logic        err_q, err_d;

   logic        dec_is_note;
   logic [1:0]  dec_skip_len;
   byte_class_e byte_cls;

   midi_status_decode #(
      .CHANNEL (CHANNEL),
      .OMNI    (OMNI)
   ) u_decode (
      .status_i   (bus.i_byte),
      .is_note_o  (dec_is_note),
      .skip_len_o (dec_skip_len)
   );

   assign byte_cls = classify(bus.i_byte);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d    = state_q;
      is_on_d    = is_on_q;
      skip_len_d = skip_len_q;
      key_d      = key_q;
      note_d     = note_q;
      vel_d      = vel_q;
      gate_d     = gate_q;
      on_d       = 1'b0;
      off_d      = 1'b0;
      err_d      = 1'b0;

      if (bus.i_byte_valid) begin
         unique case (byte_cls)
            CLS_RT:  ;
            CLS_SYS: state_d = ST_IDLE;
            CLS_STATUS: begin
               is_on_d    = (bus.i_byte[7:4] == NOTE_ON);
               skip_len_d = dec_skip_len;
               state_d    = dec_is_note ? ST_D1 : ST_SKIP1;
            end
            CLS_DATA: begin
               unique case (state_q)
                  ST_IDLE: err_d = 1'b1;
                  ST_D1: begin
                     key_d   = bus.i_byte[6:0];
                     state_d = ST_D2;
                  end
                  ST_D2: begin
                     state_d = ST_D1;
                     // A note-on with zero velocity is a note-off by MIDI convention.
                     if (is_on_q && (bus.i_byte[6:0] != 7'd0)) begin
                        note_d = key_q;
                        vel_d  = bus.i_byte[6:0];
                        gate_d = 1'b1;
                        on_d   = 1'b1;
                     end else if (gate_q && (key_q == note_q)) begin
                        gate_d = 1'b0;
                        off_d  = 1'b1;
                     end
                  end
                  ST_SKIP1: state_d = (skip_len_q == 2'd2) ? ST_SKIP2 : ST_SKIP1;
                  ST_SKIP2: state_d = ST_SKIP1;
                  default:  state_d = ST_IDLE;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         is_on_q    <= 1'b0;
         skip_len_q <= 2'd0;
         key_q      <= 7'd0;
         note_q     <= 7'd0;
         vel_q      <= 7'd0;
         gate_q     <= 1'b0;
         on_q       <= 1'b0;
         off_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q    <= state_d;
         is_on_q    <= is_on_d;
         skip_len_q <= skip_len_d;
         key_q      <= key_d;
         note_q     <= note_d;
         vel_q      <= vel_d;
         gate_q     <= gate_d;
         on_q       <= on_d;
         off_q      <= off_d;
         err_q      <= err_d;
      end
   end

   assign bus.o_note     = note_q;
   assign bus.o_velocity = vel_q;
   assign bus.o_gate     = gate_q;
   assign bus.o_note_on  = on_q;
   assign bus.o_note_off = off_q;
   assign bus.o_err      = err_q;

endmodule
